// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: asynchronous serial receiver (8N1 by default, LSB first).
// Synchronises the rx pin, detects the start edge, takes a majority-of-3
// sample at each bit centre and presents the byte with a one-cycle pulse.
module uart_rx_sampler #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_rate
        $error("uart_rx_sampler: CLOCK_FREQ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
        $error("uart_rx_sampler: DATA_BITS must be in 5..8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [2:0]           hist;
    logic                 maj;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;

    // Two-flop synchroniser for the asynchronous rx pin (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    always_comb rx_s = sync[1];

    // Three-sample history of the synchronised line for majority voting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 3'b111;
        end else begin
            hist <= {hist[1:0], rx_s};
        end
    end

    // Majority of the last three synchronised samples.
    always_comb maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    // Receive FSM: start qualification, data sampling, stop check, break wait.
    // armed blocks a line that is already low out of reset from being taken
    // as a start edge; it needs one high sample first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            armed        <= 1'b0;
            rx_data      <= '0;
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_s) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    rx_busy <= 1'b0;
                    cnt     <= '0;
                    if (armed && !rx_s) begin
                        state   <= S_START;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (maj) begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            idx   <= '0;
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {maj, shreg[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (maj) begin
                            rx_data  <= shreg;
                            rx_ready <= 1'b1;
                            rx_busy  <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        rx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    rx_busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Asynchronous serial receiver, 8N1 by default, LSB first; the receive counterpart of uart_tx on the same line.
- Synchronises the rx pin and finds the start-bit falling edge.
- Takes a majority-of-3 sample at each bit centre and presents the assembled byte with a one-cycle valid pulse.
- Sits between the board serial pin and the LC3 console/keyboard data path; loops back directly against uart_tx in experiments.

Parameters:
- CLOCK_FREQ, 12000000, system clock in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame (5..8).
- Derived, not overridable: CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (104 at defaults); HALF_BIT = CLKS_PER_BIT/2 (52).
- Elaboration error if CLKS_PER_BIT < 8.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- rx_ready  output  1  one-cycle pulse, rx_data valid on the same cycle.
- rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
- rx_busy  output  1  high from start-edge detection until frame end.

Behaviour:
- Reset values: rx_data=0, rx_ready=0, rx_frame_err=0, rx_busy=0. Synchroniser flops=1, 3-bit sample history=3'b111, state=IDLE, counters=0.
- Reset is honoured at any time, including mid-frame. After release, nothing is reported until a fresh falling edge follows at least one high sync sample.
- Input path: 2-FF synchroniser gives rx_s. A 3-bit shift history of rx_s feeds maj = majority(history).
- IDLE: rx_busy=0. When rx_s==0, go to START, clear the cycle counter, set rx_busy=1.
- START: count cycles. At counter==HALF_BIT-1, evaluate maj.
  - maj==1: glitch. Return to IDLE; no pulse, rx_data unchanged.
  - maj==0: clear counter, bit index=0, go to DATA.
- DATA: at counter==CLKS_PER_BIT-1, shift maj into the MSB of the shift register (LSB arrives first) and clear the counter. After DATA_BITS samples go to STOP.
- STOP: at counter==CLKS_PER_BIT-1, evaluate maj.
  - maj==1: load rx_data from the shift register, pulse rx_ready for exactly one cycle, go to IDLE. Re-arming at mid-stop allows back-to-back frames with zero idle.
  - maj==0: pulse rx_frame_err for one cycle, leave rx_data unchanged, go to BREAK.
- BREAK: rx_busy stays 1 until rx_s==1, then go to IDLE. A held-low line produces exactly one frame error, not repeated frames.
- Latency: rx_ready rises 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT cycles after the first clk edge that sees rx low, ±2 cycles. At defaults that is 990 ±2 cycles.
- rx_ready and rx_frame_err are mutually exclusive and never asserted in consecutive cycles.
- Baud tolerance: frames with ±2% rate mismatch must decode correctly.
- Counter width: $clog2(CLKS_PER_BIT). No wrap occurs inside a bit because the counter clears at CLKS_PER_BIT-1.
- No flow control: an unread byte is overwritten by the next good frame. The consumer must capture rx_data on rx_ready.

Test Plan:
- Defaults, single frame 0x41 (bit period 8680 ns), idle before and after -> exactly one rx_ready pulse, rx_data=0x41, 990±2 cycles after the start edge; rx_frame_err never set.
- Back-to-back 0xAA then 0x55 with no idle between the stop bit and the next start bit -> two rx_ready pulses about 1040 cycles apart, values 0xAA then 0x55.
- 20-cycle low glitch on an idle line -> rx_busy pulses high about 52 cycles then falls; no rx_ready or rx_frame_err; rx_data unchanged.
- Frame 0x41 with stop bit driven 0 and the line held low 3 bit periods -> one rx_frame_err pulse, rx_data stays at the previous 0x41, rx_busy stays high until the line returns high. A following 0x62 is then received correctly.
- rst asserted for 3 cycles during data bit 4 of 0x33 -> all outputs are 0 immediately (async). The partial frame is never reported; the next frame 0x7E decodes correctly.
- Loopback: uart_tx (same parameters) sends 0xAA then 0xBB, and separately a BFM sends 0xC3 at 1.02× and 0.98× baud -> rx_data sequence 0xAA, 0xBB, 0xC3, 0xC3 with no frame errors.
